fog_loop_core_v2: RTL and testbench
===================================

Name: fog_loop_core_v2

Overview:
Parametrised single-clock closed-loop FOG core. It generates the square-wave bias modulation and demodulates the signed ADC stream using a settle window and a power-of-two average per half-period. It integrates the demodulated error into a feedback step and accumulates the step into a wrapping phase ramp. It sits between the ADC front-end FIR and the DAC driver. New capabilities: generic widths, per-period config latching, explicit loop modes, saturating integration, ramp-wrap and config-error flags.

Parameters:
ADC_BIT, 14, width of signed ADC sample
OUT_BIT, 32, width of o_err, o_step, o_mod, o_dac
RAMP_BIT, 16, phase-ramp width; 2^RAMP_BIT equals 2π
AVG_MAX_LOG2, 6, maximum log2 of samples averaged per half-period

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_adc  in  ADC_BIT  signed ADC sample, valid every clock
i_freq_cnt  in  32  half-period length in clocks (unsigned)
i_amp_H, i_amp_L  in  OUT_BIT  signed modulation levels
i_polarity  in  1  1 = negate error
i_wait_cnt  in  32  settle clocks after each modulation edge
i_avg_sel  in  4  log2 of averaged samples (clamped to AVG_MAX_LOG2)
i_err_offset  in  OUT_BIT  signed offset added to error
i_mode  in  2  0 = OPEN, 1 = CLOSED, 2 = HOLD, 3 = treated as HOLD
i_const_step  in  OUT_BIT  step value in OPEN mode
i_gain_sel  in  5  error right-shift for step integration
i_ramp_gain_sel  in  5  step right-shift for ramp increment
o_mod  out  OUT_BIT  current modulation level
o_status  out  1  1 = high half-period
o_err  out  OUT_BIT  demodulated error
o_err_vld  out  1  one-clock pulse when o_err updates
o_step  out  OUT_BIT  feedback step
o_phase_ramp  out  RAMP_BIT  phase ramp, wraps modulo 2^RAMP_BIT
o_ramp_wrap  out  1  one-clock pulse on ramp overflow or underflow
o_dac  out  OUT_BIT  o_mod plus sign-extended o_phase_ramp, wrapping add
o_cfg_err  out  1  sticky flag: half-period too short for the settle and average window

Behaviour:
- Reset: every output and internal register is 0. i_rst asserted mid-period aborts all state in the same edge, including partial sums.
- First clock after reset release starts a period in the high half: o_status=1, o_mod=i_amp_H.
- Half-period counter: runs 0..F-1, where F = max(i_freq_cnt, 2). At F-1 the half toggles: o_status flips and o_mod takes amp_H or amp_L in the same edge.
- Config latching: i_freq_cnt, i_wait_cnt and i_avg_sel are latched only at the start of each high half. Changes mid-period have no effect until the next period.
- Demod FSM, run per half:
  - WAIT: count the latched wait clocks; a wait of 0 skips directly to ACC.
  - ACC: sum 2^A signed samples, where A = min(avg_sel, AVG_MAX_LOG2). Accumulator width is ADC_BIT+AVG_MAX_LOG2.
  - DONE: hold avg = sum >>> A, arithmetic shift.
  - Every half edge returns the FSM to WAIT.
  - If the edge arrives while in WAIT or ACC, that half is invalid and o_cfg_err is set. The flag clears only on reset.
- Error: at the end of each low half (period boundary) with both halves valid:
  - e = avg_H − avg_L, negated if i_polarity=1, then + i_err_offset, saturated to OUT_BIT.
  - o_err and o_err_vld update on the first clock of the next period.
  - If either half was invalid: no pulse, and o_err holds its value.
- Step, updated on the clock after o_err_vld:
  - CLOSED: o_step = sat(o_step + (o_err >>> i_gain_sel)).
  - OPEN: o_step = i_const_step, loaded every clock.
  - HOLD: o_step unchanged.
- Ramp: at each period start, except the very first after reset:
  - In CLOSED or OPEN, o_phase_ramp += (o_step >>> i_ramp_gain_sel), truncated to RAMP_BIT.
  - o_ramp_wrap pulses when the signed increment crosses the 0 / 2^RAMP_BIT boundary.
  - HOLD: no change.
- Saturation: clamp to [−2^(OUT_BIT−1), 2^(OUT_BIT−1)−1]. No wrap is allowed on o_step or o_err.
- o_dac is registered from the current o_mod and o_phase_ramp, so it carries 1 clock of latency.

Decomposition:
- Package fog_pkg holds:
  - the loop_mode_e enum (OPEN, CLOSED, HOLD);
  - the demod_state_e enum (WAIT, ACC, DONE);
  - a sat_add function parametrised by width;
  - the F_MIN=2 constant.
- Sub-module fog_demod_avg holds the WAIT/ACC/DONE FSM and accumulator for one half, producing avg and valid. It is instantiated once and reused for both halves via o_status.

Test Plan:
- freq=100, wait=10, avg_sel=4, ADC=1000 in high half and 200 in low half, offset=0, pol=0 → o_err_vld at clock 201, o_err=800; with pol=1 → −800.
- CLOSED, gain_sel=3, ramp_gain_sel=0, constant error 800 → o_step = 100, 200, 300 on successive periods; the ramp increments by the prior step and o_ramp_wrap fires when the ramp passes 65535.
- freq=20, wait=15, avg_sel=4 → o_cfg_err=1, no o_err_vld, o_err holds its value; stays set after freq is restored to 100 until i_rst.
- i_freq_cnt changed from 100 to 50 at clock 60 of a period → the current period remains 100 and 100; the next period is 50 and 50.
- OPEN with const_step=−5, ramp at 2 → the ramp goes to 65533 with an o_ramp_wrap pulse; switch to HOLD → the ramp and step freeze.
- i_rst asserted for 1 clock mid-ACC → all outputs 0 next clock; the first period after release restarts in the high half with no stale o_err_vld.

Source files
------------

// File: rtl/fog_pkg.sv
// Shared types and helpers for the FOG closed-loop core.
//   loop_mode_e   : feedback loop mode (OPEN / CLOSED / HOLD)
//   demod_state_e : per-half demodulator state (WAIT / ACC / DONE)
//   F_MIN         : smallest legal half-period length in clocks
//   sat_add       : signed add clamped to a w-bit two's-complement range
package fog_pkg;

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    CLOSED = 2'd1,
    HOLD   = 2'd2
  } loop_mode_e;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } demod_state_e;

  localparam int unsigned F_MIN = 2;

  // Operands are carried sign-extended in 64 bits; the sum is formed in 65
  // bits so it cannot wrap before being clamped to the w-bit range.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi)      return hi[63:0];
    else if (s < lo) return lo[63:0];
    else             return s[63:0];
  endfunction

endpackage

// File: rtl/fog_demod_avg.sv
// Per-half demodulator: after each restart, waits wait_cfg settle clocks,
// then sums 2^a_cfg signed samples and holds their arithmetic-shift average.
//   clk, rst  : clock, synchronous active-high reset
//   restart   : half-period edge, returns the FSM to the settle window
//   adc       : signed sample, one per clock
//   wait_cfg  : settle clocks (0 skips straight to accumulation)
//   a_cfg     : log2 of the number of samples averaged (already clamped)
//   avg       : average of the most recently completed window
//   vld       : 1 while the current half has a completed average
module fog_demod_avg
  import fog_pkg::*;
#(
  parameter int ADC_BIT      = 14,
  parameter int AVG_MAX_LOG2 = 6,
  parameter int AW           = $clog2(AVG_MAX_LOG2 + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restart,
  input  logic signed [ADC_BIT-1:0] adc,
  input  logic [31:0]               wait_cfg,
  input  logic [AW-1:0]             a_cfg,
  output logic signed [ADC_BIT-1:0] avg,
  output logic                      vld
);

  localparam int SW = ADC_BIT + AVG_MAX_LOG2;
  localparam int CW = AVG_MAX_LOG2 + 1;

  demod_state_e         state;
  logic [31:0]          wcnt;
  logic [CW-1:0]        acnt;
  logic [CW-1:0]        acc_last;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_n;

  always_comb begin
    sum_n    = sum + SW'(adc);
    acc_last = (CW'(1) << a_cfg) - CW'(1);
  end

  assign vld = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
      wcnt  <= '0;
      acnt  <= '0;
      sum   <= '0;
      avg   <= '0;
    end else if (restart) begin
      // A restart mid-window discards the partial sum; the half that was
      // cut short is reported invalid by the caller through vld.
      state <= (wait_cfg == 32'd0) ? ACC : WAIT;
      wcnt  <= '0;
      acnt  <= '0;
      sum   <= '0;
    end else begin
      case (state)
        WAIT: begin
          wcnt <= wcnt + 32'd1;
          if (wcnt == wait_cfg - 32'd1) state <= ACC;
        end
        ACC: begin
          sum  <= sum_n;
          acnt <= acnt + CW'(1);
          if (acnt == acc_last) begin
            state <= DONE;
            avg   <= ADC_BIT'(sum_n >>> a_cfg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fog_loop_core_v2.sv
// Closed-loop FOG core: square-wave bias modulation, per-half demodulation,
// error integration into a feedback step and a wrapping phase ramp.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_adc                : signed ADC sample, one per clock
//   i_freq_cnt           : half-period length (min F_MIN), latched per period
//   i_amp_H, i_amp_L     : modulation levels for high / low half
//   i_polarity           : 1 negates the demodulated error
//   i_wait_cnt           : settle clocks after each edge, latched per period
//   i_avg_sel            : log2 samples averaged, clamped, latched per period
//   i_err_offset         : signed offset added to the error
//   i_mode               : 0 OPEN, 1 CLOSED, 2/3 HOLD
//   i_const_step         : step used in OPEN mode
//   i_gain_sel           : error right-shift for step integration
//   i_ramp_gain_sel      : step right-shift for ramp increment
//   o_mod, o_status      : modulation level and half indicator (1 = high)
//   o_err, o_err_vld     : demodulated error and its update pulse
//   o_step               : feedback step
//   o_phase_ramp         : wrapping phase ramp
//   o_ramp_wrap          : pulse when a ramp update crosses the wrap point
//   o_dac                : o_mod + sign-extended ramp, one clock later
//   o_cfg_err            : sticky, a half ended before its average finished
module fog_loop_core_v2
  import fog_pkg::*;
#(
  parameter int ADC_BIT      = 14,
  parameter int OUT_BIT      = 32,
  parameter int RAMP_BIT     = 16,
  parameter int AVG_MAX_LOG2 = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic signed [ADC_BIT-1:0] i_adc,
  input  logic [31:0]               i_freq_cnt,
  input  logic signed [OUT_BIT-1:0] i_amp_H,
  input  logic signed [OUT_BIT-1:0] i_amp_L,
  input  logic                      i_polarity,
  input  logic [31:0]               i_wait_cnt,
  input  logic [3:0]                i_avg_sel,
  input  logic signed [OUT_BIT-1:0] i_err_offset,
  input  logic [1:0]                i_mode,
  input  logic signed [OUT_BIT-1:0] i_const_step,
  input  logic [4:0]                i_gain_sel,
  input  logic [4:0]                i_ramp_gain_sel,
  output logic signed [OUT_BIT-1:0] o_mod,
  output logic                      o_status,
  output logic signed [OUT_BIT-1:0] o_err,
  output logic                      o_err_vld,
  output logic signed [OUT_BIT-1:0] o_step,
  output logic [RAMP_BIT-1:0]       o_phase_ramp,
  output logic                      o_ramp_wrap,
  output logic signed [OUT_BIT-1:0] o_dac,
  output logic                      o_cfg_err
);

  localparam int AW = $clog2(AVG_MAX_LOG2 + 1);

  logic                      running;
  logic [31:0]               hcnt;
  logic [31:0]               f_lat;
  logic [31:0]               wait_lat;
  logic [AW-1:0]             a_lat;
  logic                      h_ok;
  logic signed [ADC_BIT-1:0] avg_h;

  logic                      half_edge;
  logic                      period_start;
  logic [31:0]               f_in;
  logic [AW-1:0]             a_in;
  logic [31:0]               wait_cfg;
  logic [AW-1:0]             a_cfg;
  loop_mode_e                mode;

  logic signed [ADC_BIT-1:0] dm_avg;
  logic                      dm_vld;

  logic signed [63:0]        diff_w;
  logic signed [63:0]        err_w;
  logic signed [63:0]        step_w;
  logic signed [63:0]        inc_w;
  logic signed [63:0]        ramp_sum;
  logic                      ramp_cross;

  always_comb begin
    f_in = (i_freq_cnt < 32'(F_MIN)) ? 32'(F_MIN) : i_freq_cnt;
    a_in = ({28'd0, i_avg_sel} > 32'(AVG_MAX_LOG2)) ? AW'(AVG_MAX_LOG2)
                                                      : AW'(i_avg_sel);

    // The very first clock after reset opens a high half without a toggle.
    half_edge    = !running || (hcnt == f_lat - 32'd1);
    period_start = !running || (half_edge && !o_status);

    // On a period start the demodulator must see the values being latched
    // this edge, not the previous period's.
    wait_cfg = period_start ? i_wait_cnt : wait_lat;
    a_cfg    = period_start ? a_in : a_lat;

    case (i_mode)
      2'd0:    mode = OPEN;
      2'd1:    mode = CLOSED;
      default: mode = HOLD;
    endcase

    diff_w = 64'(avg_h) - 64'(dm_avg);
    if (i_polarity) diff_w = -diff_w;
    err_w  = sat_add(diff_w, 64'(i_err_offset), OUT_BIT);
    step_w = sat_add(64'(o_step), 64'(o_err >>> i_gain_sel), OUT_BIT);

    // Ramp is unsigned modulo 2^RAMP_BIT; the increment is signed, so a
    // crossing in either direction shows up as the wide sum leaving range.
    inc_w      = 64'(o_step >>> i_ramp_gain_sel);
    ramp_sum   = 64'($signed({1'b0, o_phase_ramp})) + inc_w;
    ramp_cross = (ramp_sum < 64'sd0) || (ramp_sum >= (64'sd1 <<< RAMP_BIT));
  end

  fog_demod_avg #(
    .ADC_BIT      (ADC_BIT),
    .AVG_MAX_LOG2 (AVG_MAX_LOG2),
    .AW           (AW)
  ) u_demod (
    .clk      (i_clk),
    .rst      (i_rst),
    .restart  (half_edge),
    .adc      (i_adc),
    .wait_cfg (wait_cfg),
    .a_cfg    (a_cfg),
    .avg      (dm_avg),
    .vld      (dm_vld)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      running      <= 1'b0;
      hcnt         <= '0;
      f_lat        <= '0;
      wait_lat     <= '0;
      a_lat        <= '0;
      h_ok         <= 1'b0;
      avg_h        <= '0;
      o_mod        <= '0;
      o_status     <= 1'b0;
      o_err        <= '0;
      o_err_vld    <= 1'b0;
      o_step       <= '0;
      o_phase_ramp <= '0;
      o_ramp_wrap  <= 1'b0;
      o_dac        <= '0;
      o_cfg_err    <= 1'b0;
    end else begin
      o_err_vld   <= 1'b0;
      o_ramp_wrap <= 1'b0;

      // Output stage: DAC word from the current modulation and ramp.
      o_dac <= o_mod + OUT_BIT'($signed(o_phase_ramp));

      // Step stage: integrates the error registered on the previous clock.
      case (mode)
        OPEN:    o_step <= i_const_step;
        CLOSED:  if (o_err_vld) o_step <= OUT_BIT'(step_w);
        default: ;
      endcase

      // Modulation / half-period stage.
      if (period_start) begin
        f_lat    <= f_in;
        wait_lat <= i_wait_cnt;
        a_lat    <= a_in;
      end

      if (!running) begin
        running  <= 1'b1;
        hcnt     <= '0;
        o_status <= 1'b1;
        o_mod    <= i_amp_H;
      end else if (half_edge) begin
        hcnt <= '0;
        if (!dm_vld) o_cfg_err <= 1'b1;
        if (o_status) begin
          o_status <= 1'b0;
          o_mod    <= i_amp_L;
          h_ok     <= dm_vld;
          avg_h    <= dm_avg;
        end else begin
          o_status <= 1'b1;
          o_mod    <= i_amp_H;
          if (h_ok && dm_vld) begin
            o_err     <= OUT_BIT'(err_w);
            o_err_vld <= 1'b1;
          end
          if (mode != HOLD) begin
            o_phase_ramp <= RAMP_BIT'(ramp_sum);
            o_ramp_wrap  <= ramp_cross;
          end
        end
      end else begin
        hcnt <= hcnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fog_loop_core_v2.sv
`timescale 1ns/1ps
module tb_fog_loop_core_v2;

  localparam int ADC_BIT      = 14;
  localparam int OUT_BIT      = 32;
  localparam int RAMP_BIT     = 16;
  localparam int AVG_MAX_LOG2 = 6;

  localparam logic [1:0] M_OPEN   = 2'd0;
  localparam logic [1:0] M_CLOSED = 2'd1;
  localparam logic [1:0] M_HOLD   = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic signed [ADC_BIT-1:0] adc, adc_h, adc_l;
  logic [31:0]               freq_cnt, wait_cnt;
  logic signed [OUT_BIT-1:0] amp_h, amp_l, err_offset, const_step;
  logic                      polarity;
  logic [3:0]                avg_sel;
  logic [1:0]                mode;
  logic [4:0]                gain_sel, ramp_gain_sel;

  logic signed [OUT_BIT-1:0] mod_o, err_o, step_o, dac_o;
  logic                      status, err_vld, ramp_wrap, cfg_err;
  logic [RAMP_BIT-1:0]       ramp;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  assign adc = status ? adc_h : adc_l;

  always #5 clk = ~clk;

  fog_loop_core_v2 #(
    .ADC_BIT(ADC_BIT), .OUT_BIT(OUT_BIT), .RAMP_BIT(RAMP_BIT),
    .AVG_MAX_LOG2(AVG_MAX_LOG2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_adc(adc), .i_freq_cnt(freq_cnt),
    .i_amp_H(amp_h), .i_amp_L(amp_l), .i_polarity(polarity),
    .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel), .i_err_offset(err_offset),
    .i_mode(mode), .i_const_step(const_step), .i_gain_sel(gain_sel),
    .i_ramp_gain_sel(ramp_gain_sel), .o_mod(mod_o), .o_status(status),
    .o_err(err_o), .o_err_vld(err_vld), .o_step(step_o),
    .o_phase_ramp(ramp), .o_ramp_wrap(ramp_wrap), .o_dac(dac_o),
    .o_cfg_err(cfg_err)
  );

  typedef struct {
    string  name;
    int     freq;
    int     wait_c;
    int     avg;
    int     a_h;
    int     a_l;
    bit     pol;
    longint off;
    longint exp_err;
    int     exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, status, 0);
    check({tag, "_mod"}, mod_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_err_vld"}, err_vld, 0);
    check({tag, "_step"}, step_o, 0);
    check({tag, "_ramp"}, ramp, 0);
    check({tag, "_dac"}, dac_o, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  task automatic set_cfg(input int f, input int w, input int a);
    freq_cnt = 32'(f);
    wait_cnt = 32'(w);
    avg_sel  = 4'(a);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     vcyc;
    int     cnt;
    longint r_exp;
    longint r_full;
    longint s_prev;
    bit     w_exp;

    vecs[0] = '{"basic",     100, 10, 4,  1000,  200, 1'b0, 0,   800, 201};
    vecs[1] = '{"pol",       100, 10, 4,  1000,  200, 1'b1, 0,  -800, 201};
    vecs[2] = '{"offset",     40,  3, 2,  -300,  500, 1'b0, 50, -750,  81};
    vecs[3] = '{"sat_hi",     10,  0, 0,   400, -400, 1'b0, 64'sd2147483637, 64'sd2147483647, 21};
    vecs[4] = '{"sat_lo_f0",   0,  0, 0, -8192, 8191, 1'b0, -64'sd2147483648, -64'sd2147483648, 5};
    vecs[5] = '{"avg_clamp", 100,  5, 15, 8191, -8192, 1'b0, 0, 16383, 201};
    vecs[6] = '{"pol_off",    30,  2, 3,   100,  -20, 1'b1, -7, -127,  61};

    rst = 1'b1;
    amp_h = 32'sd1000;  amp_l = -32'sd1000;
    adc_h = '0;  adc_l = '0;
    polarity = 1'b0;  err_offset = '0;  const_step = '0;
    mode = M_HOLD;  gain_sel = '0;  ramp_gain_sel = '0;
    set_cfg(100, 10, 4);

    // Reset state
    tick();
    tick();
    check_all_zero("reset");

    // Table-driven error vectors
    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].freq, vecs[i].wait_c, vecs[i].avg);
      adc_h      = 14'(vecs[i].a_h);
      adc_l      = 14'(vecs[i].a_l);
      polarity   = vecs[i].pol;
      err_offset = 32'(vecs[i].off);
      mode       = M_HOLD;
      do_reset();
      vcyc = -1;
      for (int c = 0; c < 2000; c++) begin
        tick();
        if (err_vld) begin
          vcyc = cyc;
          break;
        end
      end
      check({vecs[i].name, "_vld_cycle"}, vcyc, vecs[i].exp_cyc);
      check({vecs[i].name, "_err"}, err_o, vecs[i].exp_err);
      check({vecs[i].name, "_cfg_err"}, cfg_err, 0);
    end

    // CLOSED integration and ramp wrap
    set_cfg(100, 10, 4);
    adc_h = 14'sd1000;  adc_l = 14'sd200;
    polarity = 1'b0;  err_offset = '0;
    mode = M_CLOSED;  gain_sel = 5'd3;  ramp_gain_sel = 5'd0;
    do_reset();
    run_to(1);
    check("first_status", status, 1);
    check("first_mod", mod_o, 1000);
    check("dac_latency_c1", dac_o, 0);
    run_to(2);
    check("dac_latency_c2", dac_o, 1000);
    r_exp = 0;
    for (int p = 1; p <= 40; p++) begin
      s_prev = 100 * (p - 1);
      r_full = r_exp + s_prev;
      w_exp  = (r_full > 65535);
      r_exp  = r_full % 65536;
      run_to(200 * p + 1);
      if (p <= 3) begin
        check("closed_err_vld", err_vld, 1);
        check("closed_err", err_o, 800);
      end
      check("closed_ramp", ramp, r_exp);
      check("closed_wrap", ramp_wrap, w_exp);
      run_to(200 * p + 2);
      check("closed_step", step_o, 100 * p);
      check("closed_wrap_pulse", ramp_wrap, 0);
      if (p == 1) check("closed_vld_pulse", err_vld, 0);
    end

    // Configuration error: window does not fit, sticky until reset
    mode = M_HOLD;
    set_cfg(100, 10, 4);
    do_reset();
    run_to(250);
    set_cfg(20, 15, 4);
    run_to(401);
    check("cfg_err_vld_401", err_vld, 1);
    check("cfg_err_err_401", err_o, 800);
    run_to(420);
    check("cfg_err_before", cfg_err, 0);
    run_to(421);
    check("cfg_err_set", cfg_err, 1);
    cnt = 0;
    while (cyc < 600) begin
      tick();
      if (err_vld) cnt++;
    end
    check("cfg_err_no_vld", cnt, 0);
    check("cfg_err_err_hold", err_o, 800);
    set_cfg(100, 10, 4);
    run_to(801);
    check("cfg_err_recover_vld", err_vld, 1);
    check("cfg_err_sticky", cfg_err, 1);
    do_reset();
    check("cfg_err_cleared", cfg_err, 0);

    // Frequency latching only at period start
    set_cfg(100, 10, 4);
    do_reset();
    run_to(60);
    freq_cnt = 32'd50;
    run_to(100); check("freq_c100", status, 1);
    run_to(101); check("freq_c101", status, 0);
    run_to(200); check("freq_c200", status, 0);
    run_to(201); check("freq_c201", status, 1);
    run_to(250); check("freq_c250", status, 1);
    run_to(251); check("freq_c251", status, 0);
    run_to(300); check("freq_c300", status, 0);
    run_to(301); check("freq_c301", status, 1);

    // OPEN ramp underflow, then HOLD freeze
    set_cfg(10, 0, 0);
    mode = M_OPEN;  const_step = 32'sd2;  ramp_gain_sel = 5'd0;
    do_reset();
    run_to(21);
    check("open_ramp_2", ramp, 2);
    check("open_wrap_0", ramp_wrap, 0);
    check("open_step_2", step_o, 2);
    const_step = -32'sd5;
    run_to(22);
    check("open_step_m5", step_o, -5);
    run_to(41);
    check("open_ramp_under", ramp, 65533);
    check("open_wrap_1", ramp_wrap, 1);
    run_to(42);
    check("open_wrap_pulse", ramp_wrap, 0);
    check("open_dac", dac_o, 997);
    run_to(45);
    mode = M_HOLD;  const_step = 32'sd7;
    run_to(46);
    check("hold_step", step_o, -5);
    run_to(61);
    check("hold_ramp_61", ramp, 65533);
    run_to(81);
    check("hold_ramp_81", ramp, 65533);
    check("hold_step_81", step_o, -5);
    check("hold_wrap", ramp_wrap, 0);

    // Reset mid-accumulation
    set_cfg(100, 10, 4);
    mode = M_CLOSED;  gain_sel = 5'd3;
    adc_h = 14'sd1000;  adc_l = 14'sd200;
    do_reset();
    run_to(215);
    check("mid_step_pre", step_o, 100);
    check("mid_err_pre", err_o, 800);
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    cyc = 0;
    cnt = 0;
    tick();
    check("mid_restart_status", status, 1);
    if (err_vld) cnt++;
    while (cyc < 200) begin
      tick();
      if (err_vld) cnt++;
    end
    check("mid_no_stale_vld", cnt, 0);
    run_to(201);
    check("mid_vld_201", err_vld, 1);
    check("mid_err_201", err_o, 800);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
